// File: rtl/shifter_pkg.sv
// Shared types for the sequential multi-mode shifter.
package shifter_pkg;

  // Shift mode encoding as presented on the mode input.
  typedef enum logic [1:0] {
    SH_ASR = 2'b00,
    SH_LSR = 2'b01,
    SH_LSL = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_e;

  // Control states of the shifter.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift_stage.sv
// Combinational shift of one word by 0..STEP positions in a selectable mode.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1,
  parameter int unsigned KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    k,
  input  shift_mode_e      mode,
  output logic [WIDTH-1:0] shifted_c
);

  logic [2*WIDTH-1:0] dbl_c;

  // Rotate is taken from the low half of the doubled word shifted right.
  always_comb begin
    dbl_c     = {data, data} >> k;
    shifted_c = data;
    case (mode)
      SH_ASR:  shifted_c = WIDTH'($signed(data) >>> k);
      SH_LSR:  shifted_c = data >> k;
      SH_LSL:  shifted_c = data << k;
      SH_ROR:  shifted_c = dbl_c[WIDTH-1:0];
      default: shifted_c = data;
    endcase
  end

endmodule

// File: rtl/seq_multi_shifter.sv
// Sequential shifter: loads an operand, then shifts up to STEP bits per clock.
module seq_multi_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1,
  parameter int unsigned AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    amt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned KW = $clog2(STEP + 1);

  shift_state_e     state_q, state_d;
  shift_mode_e      mode_q, mode_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] out_d;
  logic [KW-1:0]    k_c;
  logic [WIDTH-1:0] shifted_c;

  // Step size this cycle: whole STEP, or whatever distance is left.
  always_comb begin
    if (32'(rem_q) >= STEP) k_c = KW'(STEP);
    else                    k_c = KW'(rem_q);
  end

  shift_stage #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_stage (
    .data      (out),
    .k         (k_c),
    .mode      (mode_q),
    .shifted_c (shifted_c)
  );

  // Next-state and datapath update; start is only honoured outside SHIFT.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    out_d   = out;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          out_d   = in_data;
          rem_d   = amt;
          mode_d  = shift_mode_e'(mode);
          state_d = (amt != '0) ? S_SHIFT : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        out_d = shifted_c;
        rem_d = rem_q - AW'(k_c);
        if (rem_q == AW'(k_c)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, working register, remaining distance and latched mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= SH_ASR;
      rem_q   <= '0;
      out     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      out     <= out_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_multi_shifter.sv
// Directed and swept checks of seq_multi_shifter across several WIDTH/STEP builds.
module tb_seq_multi_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  start_v;
  logic [15:0] in_data;
  logic [3:0]  amt;
  logic [1:0]  mode;
  logic [5:0]  busy_v, done_v;
  logic [15:0] o0, o1, o2, o3;
  logic [7:0]  o4, o5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_multi_shifter #(.WIDTH(16), .STEP(1)) u_w16s1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_data(in_data), .amt(amt),
    .mode(mode), .busy(busy_v[0]), .done(done_v[0]), .out(o0));
  seq_multi_shifter #(.WIDTH(16), .STEP(2)) u_w16s2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_data(in_data), .amt(amt),
    .mode(mode), .busy(busy_v[1]), .done(done_v[1]), .out(o1));
  seq_multi_shifter #(.WIDTH(16), .STEP(4)) u_w16s4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_data(in_data), .amt(amt),
    .mode(mode), .busy(busy_v[2]), .done(done_v[2]), .out(o2));
  seq_multi_shifter #(.WIDTH(16), .STEP(16)) u_w16s16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .in_data(in_data), .amt(amt),
    .mode(mode), .busy(busy_v[3]), .done(done_v[3]), .out(o3));
  seq_multi_shifter #(.WIDTH(8), .STEP(1)) u_w8s1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[4]), .in_data(in_data[7:0]), .amt(amt[2:0]),
    .mode(mode), .busy(busy_v[4]), .done(done_v[4]), .out(o4));
  seq_multi_shifter #(.WIDTH(8), .STEP(8)) u_w8s8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[5]), .in_data(in_data[7:0]), .amt(amt[2:0]),
    .mode(mode), .busy(busy_v[5]), .done(done_v[5]), .out(o5));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cur_out(input int idx);
    case (idx)
      0: return o0;
      1: return o1;
      2: return o2;
      3: return o3;
      4: return {8'h00, o4};
      default: return {8'h00, o5};
    endcase
  endfunction

  // Bit-serial reference: apply n single-position shifts within w bits.
  function automatic logic [15:0] ref_shift(input int w, input logic [15:0] d_in,
                                            input int n, input logic [1:0] m);
    logic [15:0] d;
    logic [15:0] mask;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    d = d_in & mask;
    for (int i = 0; i < n; i++) begin
      case (m)
        2'b00: d = (d >> 1) | (16'(d[w-1]) << (w - 1));
        2'b01: d = d >> 1;
        2'b10: d = (d << 1) & mask;
        default: d = (d >> 1) | (16'(d[0]) << (w - 1));
      endcase
    end
    return d;
  endfunction

  // Present an operation; call at a falling edge.
  task automatic start_op(input int idx, input logic [15:0] d, input int n, input logic [1:0] m);
    in_data      = d;
    amt          = 4'(n);
    mode         = m;
    start_v[idx] = 1'b1;
  endtask

  // Count edges from the accepting edge until done is seen; optionally poke a
  // start while busy, or check the operand load on the accepting edge.
  task automatic wait_done(input int idx, input int poke, input bit lchk, input logic [15:0] lexp,
                           output logic [15:0] res, output int cyc, output int bcnt);
    bit got_done;
    got_done = 1'b0;
    cyc  = 0;
    bcnt = 0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk);
      cyc++;
      if (lchk && cyc == 1) begin
        #1;
        check("b2b_load", 32'(cur_out(idx)), 32'(lexp));
      end
      @(negedge clk);
      start_v[idx] = 1'b0;
      if (done_v[idx]) begin
        got_done = 1'b1;
        break;
      end
      if (busy_v[idx]) bcnt++;
      if (poke != 0 && cyc == poke) begin
        start_v[idx] = 1'b1;
        in_data      = 16'h1234;
        amt          = 4'd1;
        mode         = 2'b10;
      end
    end
    check("done_seen", 32'(got_done), 32'd1);
    res = cur_out(idx);
  endtask

  logic [15:0] res;
  int          cyc, bcnt;

  initial begin
    logic [15:0] mode_exp [4];
    int          steps [6];
    mode_exp = '{16'hF000, 16'h1000, 16'h0008, 16'h3000};
    steps    = '{1, 2, 4, 16, 1, 8};

    rst_n   = 1'b0;
    start_v = '0;
    in_data = '0;
    amt     = '0;
    mode    = '0;
    repeat (2) @(negedge clk);
    check("rst_out", 32'(o0), 32'h0);
    check("rst_busy", 32'(busy_v), 32'h0);
    check("rst_done", 32'(done_v), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Each mode on 16'h8001 by 3, single-bit steps.
    for (int m = 0; m < 4; m++) begin
      start_op(0, 16'h8001, 3, 2'(m));
      wait_done(0, 0, 1'b0, 16'h0, res, cyc, bcnt);
      check($sformatf("mode%0d_out", m), 32'(res), 32'(mode_exp[m]));
      check($sformatf("mode%0d_cyc", m), 32'(cyc), 32'd4);
      check($sformatf("mode%0d_busy", m), 32'(bcnt), 32'd3);
    end

    // Zero distance goes straight to done.
    start_op(0, 16'hA5A5, 0, 2'b00);
    wait_done(0, 0, 1'b0, 16'h0, res, cyc, bcnt);
    check("zero_out", 32'(res), 32'hA5A5);
    check("zero_cyc", 32'(cyc), 32'd1);
    check("zero_busy", 32'(bcnt), 32'd0);

    // Four-bit steps.
    start_op(2, 16'h8000, 6, 2'b00);
    wait_done(2, 0, 1'b0, 16'h0, res, cyc, bcnt);
    check("s4_amt6_out", 32'(res), 32'hFE00);
    check("s4_amt6_cyc", 32'(cyc), 32'd3);
    start_op(2, 16'h8000, 15, 2'b00);
    wait_done(2, 0, 1'b0, 16'h0, res, cyc, bcnt);
    check("s4_amt15_out", 32'(res), 32'hFFFF);
    check("s4_amt15_cyc", 32'(cyc), 32'd5);

    // Start pulse during SHIFT must be ignored.
    start_op(0, 16'h00F0, 5, 2'b01);
    wait_done(0, 2, 1'b0, 16'h0, res, cyc, bcnt);
    check("busy_start_out", 32'(res), 32'h0007);
    check("busy_start_cyc", 32'(cyc), 32'd6);

    // Back-to-back: new start in the done cycle.
    start_op(0, 16'h0001, 2, 2'b10);
    wait_done(0, 0, 1'b0, 16'h0, res, cyc, bcnt);
    check("b2b_first_out", 32'(res), 32'h0004);
    start_op(0, 16'hBEEF, 4, 2'b01);
    wait_done(0, 0, 1'b1, 16'hBEEF, res, cyc, bcnt);
    check("b2b_second_out", 32'(res), 32'h0BEE);
    check("b2b_second_cyc", 32'(cyc), 32'd5);

    // Asynchronous reset in the middle of a shift.
    start_op(0, 16'h8001, 10, 2'b00);
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(o0), 32'h0);
    check("midrst_busy", 32'(busy_v[0]), 32'h0);
    check("midrst_done", 32'(done_v[0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(0, 16'h8001, 3, 2'b11);
    wait_done(0, 0, 1'b0, 16'h0, res, cyc, bcnt);
    check("post_rst_out", 32'(res), 32'h3000);
    check("post_rst_cyc", 32'(cyc), 32'd4);

    // Random sweep over all builds.
    for (int i = 0; i < 1000; i++) begin
      int          idx, w, n;
      logic [15:0] d, exp;
      logic [1:0]  m;
      idx = i % 6;
      w   = (idx >= 4) ? 8 : 16;
      d   = 16'($urandom);
      n   = int'($urandom_range(0, w - 1));
      m   = 2'($urandom);
      exp = ref_shift(w, d, n, m);
      start_op(idx, d, n, m);
      wait_done(idx, 0, 1'b0, 16'h0, res, cyc, bcnt);
      check($sformatf("rnd%0d_i%0d_out", i, idx), 32'(res), 32'(exp));
      check($sformatf("rnd%0d_i%0d_cyc", i, idx), 32'(cyc), 32'((n + steps[idx] - 1) / steps[idx] + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
